// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with line refill FSM
//
// Sits between the CPU instruction-fetch port and a req/ack system memory bus.
// Hits are answered combinationally in the request cycle; a miss holds
// instr_mem_ready_o low while the line is fetched one word per bus ack.
//
// Optional feature: define ICACHE_FLUSH_EN to add the flush_i invalidate port.
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous reset, active-high
//   flush_i            (ICACHE_FLUSH_EN only) invalidate all lines
//   instr_mem_rd_i     CPU fetch request
//   instr_mem_addr_i   CPU fetch byte address, bits [1:0] ignored
//   instr_mem_data_o   instruction word (0 when not hitting)
//   instr_mem_ready_o  data valid / CPU may advance
//   mem_req_o          bus read request, held until mem_ack_i
//   mem_addr_o         bus byte address of the requested word
//   mem_ack_i          bus read complete, mem_data_i valid
//   mem_data_i         bus read data

module instr_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef ICACHE_FLUSH_EN
  input  logic        flush_i,
`endif
  input  logic        instr_mem_rd_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic [31:0] instr_mem_data_o,
  output logic        instr_mem_ready_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t state;

  // Storage: register-based arrays with combinational read.
  logic [31:0]      data_mem [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  // Refill context, captured at miss detection so that a CPU address change
  // during the refill cannot redirect where the line is written.
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFF_W-1:0] cnt;

  // Address decode of the current CPU request.
  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             flush_now;

  assign addr_off = instr_mem_addr_i[OFF_W+1:2];
  assign addr_idx = instr_mem_addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign addr_tag = instr_mem_addr_i[31:IDX_W+OFF_W+2];

  assign hit = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);

`ifdef ICACHE_FLUSH_EN
  logic flush_pending;
  // A flush seen in IDLE takes effect at the next edge; it suppresses ready
  // in its own cycle so the CPU never consumes a line being invalidated.
  assign flush_now = flush_i && (state == IDLE);
`else
  assign flush_now = 1'b0;
`endif

  // Ready must stay high whenever rd is low: the CPU drops rd during
  // data-side stalls and would deadlock otherwise.
  assign instr_mem_ready_o = !instr_mem_rd_i || ((state == IDLE) && hit && !flush_now);
  assign instr_mem_data_o  = hit ? data_mem[addr_idx][addr_off] : 32'd0;

  // Control FSM with registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'd0;
`ifdef ICACHE_FLUSH_EN
      flush_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flush_now) begin
            valid <= '0;
          end else if (instr_mem_rd_i && !hit) begin
            fill_idx        <= addr_idx;
            fill_tag        <= addr_tag;
            cnt             <= '0;
            // Drop the line before it is partially overwritten so a
            // half-filled line can never produce a hit.
            valid[addr_idx] <= 1'b0;
            mem_req_o       <= 1'b1;
            mem_addr_o      <= {instr_mem_addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            state           <= REFILL;
          end
        end

        REFILL: begin
`ifdef ICACHE_FLUSH_EN
          if (flush_i) flush_pending <= 1'b1;
`endif
          if (mem_ack_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              mem_req_o <= 1'b0;
              state     <= UPDATE;
            end else begin
              // Back-to-back request: req stays high, address advances.
              mem_addr_o <= mem_addr_o + 32'd4;
            end
          end
        end

        UPDATE: begin
`ifdef ICACHE_FLUSH_EN
          // A flush that arrived during the refill wins: the fresh line is
          // left invalid together with every other line.
          if (flush_pending || flush_i) begin
            valid         <= '0;
            flush_pending <= 1'b0;
          end else begin
            valid[fill_idx] <= 1'b1;
          end
`else
          valid[fill_idx] <= 1'b1;
`endif
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Data and tag arrays are deliberately not reset; validity alone guards them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state == REFILL) && mem_ack_i) begin
      data_mem[fill_idx][cnt] <= mem_data_i;
    end
    if (!rst_i && (state == UPDATE)) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU instruction-fetch port and the slower system memory bus.
- Hits return the instruction in the same cycle. Misses stall the CPU via instr_mem_ready_o while a line-refill FSM fetches a whole line word by word over a req/ack bus.
- Sits directly upstream of the pipeline's IF stage.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- instr_mem_rd_i  in  1  CPU fetch request.
- instr_mem_addr_i  in  32  CPU fetch byte address; bits [1:0] ignored.
- instr_mem_data_o  out  32  instruction word.
- instr_mem_ready_o  out  1  data valid / CPU may advance.
- mem_req_o  out  1  bus read request.
- mem_addr_o  out  32  bus word address (byte address, bits [1:0]=0).
- mem_ack_i  in  1  bus read complete; mem_data_i valid this cycle.
- mem_data_i  in  32  bus read data.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) bits at [OFF+1:2].
  - IDX = log2(LINES) bits above OFF.
  - TAG = remaining upper bits.
- Storage: data array LINES×WORDS_PER_LINE×32, tag array, valid bit per line (register-based, combinational read).
- hit = valid[idx] & (tag[idx] == addr tag).
- instr_mem_ready_o:
  - 1 when instr_mem_rd_i=0.
  - 1 when state=IDLE and hit.
  - 0 otherwise.
  - Must never be low while rd is low, because the CPU drops rd during data-side stalls.
- instr_mem_data_o = data[idx][off] on hit; otherwise 0.
- FSM states: IDLE, REFILL, UPDATE.
  - IDLE: if rd & ~hit, latch line base address (offset=0), clear word counter, go to REFILL.
  - REFILL:
    - mem_req_o=1, mem_addr_o = base + 4·cnt, both held stable until mem_ack_i.
    - On ack: write mem_data_i into data[idx][cnt], increment cnt.
    - If cnt was WORDS_PER_LINE−1, go to UPDATE; otherwise the next request starts the following cycle (req stays high, address advances).
  - UPDATE: write tag, set valid[idx], mem_req_o=0, go to IDLE. Lookup repeats there and hits.
- Miss latency: 1 (IDLE detect) + Σ ack waits + 1 (UPDATE) cycles before ready goes high in IDLE. With single-cycle ack and 4 words: ready high 6 cycles after the miss cycle.
- mem_ack_i outside REFILL is ignored.
- valid[idx] is cleared on entering REFILL, so a half-filled line never hits.
- A CPU address change during REFILL does not abort the refill. The line completes, then the new address is looked up in IDLE.
- Conflict: a miss to the same idx with a different tag overwrites the line.
- Reset (any state, including mid-refill):
  - State=IDLE, all valid=0, cnt=0.
  - mem_req_o=0, mem_addr_o=0.
  - Data/tag arrays are not cleared.
  - instr_mem_ready_o follows its combinational rule (1 if rd=0).

Optional Feature:
- Macro ICACHE_FLUSH_EN.
- When defined: adds port flush_i (in, 1).
  - flush_i high in IDLE: all valid bits cleared at the next edge; ready forced 0 that cycle.
  - flush_i high during REFILL/UPDATE: latched as pending. The line completes but UPDATE leaves valid=0; pending clears all valid bits on return to IDLE.
  - Reset clears pending.
- When undefined: no flush_i port, no pending register; the cache is only invalidated by reset.

Test Plan:
- Cold miss: after reset, rd=1, addr=0x100; bus acks each request in 1 cycle with data 0xA0..0xA3 -> mem_addr_o sequence 0x100, 0x104, 0x108, 0x10C; ready=1 with data=0xA0 six cycles after the request.
- Hit: then addr=0x108 -> ready=1 and data=0xA2 in the same cycle, mem_req_o stays 0.
- Conflict: addr=0x100 + LINES·16 = 0x200 (default params) -> miss, refill from 0x200; a following access to 0x100 misses again.
- Bus wait states: ack delayed 3 cycles per word -> mem_req_o and mem_addr_o stable for the full wait, counter advances only on ack, ready stays 0 throughout the refill.
- Reset mid-refill: assert rst_i after the 2nd ack -> next cycle mem_req_o=0; re-request of the same address performs a full 4-word refill.
- rd low / flush (ICACHE_FLUSH_EN): rd=0 at any state -> ready=1. Pulse flush_i after a filled line -> the next access to it misses.
